exe_stage_mc: RTL and testbench

Parametrised, pipelined successor to the single-cycle ARM execute stage. It takes decoded ID/EX operands and performs the following in one cycle:
- Val2 generation (immediate rotate, register shift, memory offset).
- ALU operation and status update.
- Branch-target calculation.

MUL/MLA run on an iterative multiplier over several cycles. Results sit in an internal EX/MEM output register with a valid/ready handshake, so the stage stalls ID and honours MEM back-pressure and branch flushes.

---
 rtl/exe_pkg.sv | 33 +++
 rtl/exe_val2_gen.sv | 52 +++++
 rtl/exe_stage_mc.sv | 203 ++++++++++++++++++++
 tb/tb_exe_stage_mc.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - shared encodings for the multi-cycle execute stage
package exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam logic [1:0] MUL_NONE = 2'b00;
    localparam logic [1:0] MUL_MUL  = 2'b01;
    localparam logic [1:0] MUL_MLA  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_val2_gen.sv
// rtl/exe_val2_gen.sv - operand-2 generation (offset, rotated immediate, shifted register)
module exe_val2_gen
    import exe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              mem_en_i,
    input  logic              imm_i,
    input  logic [11:0]       shift_operand_i,
    input  logic [DATA_W-1:0] val_rm_i,
    output logic [DATA_W-1:0] val2_o
);

    localparam int SW = $clog2(DATA_W);

    logic [SW-1:0]     imm_amt;
    logic [SW-1:0]     sh_amt;
    logic [DATA_W-1:0] imm_base;
    logic [DATA_W-1:0] rm_shifted;

    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input logic [SW-1:0] amt);
        // a shift by DATA_W yields zero, so amt==0 falls out naturally
        return (x >> amt) | (x << (DATA_W - 32'(amt)));
    endfunction

    assign imm_amt  = SW'((32'(shift_operand_i[11:8]) * 2) % DATA_W);
    assign sh_amt   = SW'(32'(shift_operand_i[11:7]) % DATA_W);
    assign imm_base = DATA_W'(shift_operand_i[7:0]);

    // register operand shifted by the immediate amount using the encoded shift type
    always_comb begin
        rm_shifted = val_rm_i;
        case (shift_operand_i[6:5])
            SH_LSL:  rm_shifted = val_rm_i << sh_amt;
            SH_LSR:  rm_shifted = val_rm_i >> sh_amt;
            SH_ASR:  rm_shifted = $signed(val_rm_i) >>> sh_amt;
            SH_ROR:  rm_shifted = rotr(val_rm_i, sh_amt);
            default: rm_shifted = val_rm_i;
        endcase
    end

    // memory offsets win over immediates, which win over register operands
    always_comb begin
        val2_o = rm_shifted;
        if (mem_en_i) begin
            val2_o = DATA_W'(shift_operand_i);
        end else if (imm_i) begin
            val2_o = rotr(imm_base, imm_amt);
        end
    end

endmodule

// File: rtl/exe_stage_mc.sv
// rtl/exe_stage_mc.sv - execute stage with iterative multiplier and EX/MEM output register
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int IMM_W    = 24,
    parameter int MUL_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              s_in,
    input  logic              imm,
    input  logic [1:0]        mul_op,
    input  logic [3:0]        exe_cmd,
    input  logic [3:0]        sr,
    input  logic [3:0]        dest_in,
    input  logic [11:0]       shift_operand,
    input  logic [IMM_W-1:0]  imm_signed,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [DATA_W-1:0] val_rs,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [3:0]        dest,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] br_addr,
    output logic [DATA_W-1:0] st_val,
    output logic [3:0]        status,
    output logic              status_we,
    output logic              busy
);

    localparam int MUL_STEPS = DATA_W / MUL_BITS;
    localparam int SCW       = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam int MSB       = DATA_W - 1;

    state_t            state_q, state_d;
    logic [SCW-1:0]    step_q, step_d;
    logic [DATA_W-1:0] m_rm_q, m_rm_d, m_rs_q, m_rs_d, acc_q, acc_d;
    logic              m_s_q, m_s_d;
    logic [1:0]        m_cv_q, m_cv_d;
    logic              out_valid_q, out_valid_d, status_we_q, status_we_d;
    logic              wb_en_q, wb_en_d, mem_r_en_q, mem_r_en_d, mem_w_en_q, mem_w_en_d;
    logic [3:0]        dest_q, dest_d, status_q, status_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d, br_addr_q, br_addr_d, st_val_q, st_val_d;

    logic [DATA_W-1:0] val2, alu_res, add_b, br_calc, partial, acc_next;
    logic signed [DATA_W-1:0] imm_ext;
    logic [DATA_W:0]   sum;
    logic [3:0]        alu_flags;
    logic              add_cin, is_arith, known, accept;

    exe_val2_gen #(.DATA_W(DATA_W)) u_val2 (
        .mem_en_i        (mem_r_en_in | mem_w_en_in),
        .imm_i           (imm),
        .shift_operand_i (shift_operand),
        .val_rm_i        (val_rm),
        .val2_o          (val2)
    );

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign imm_ext  = DATA_W'($signed(imm_signed));
    assign br_calc  = pc_in + (imm_ext << 2);
    assign partial  = m_rm_q * DATA_W'(m_rs_q[MUL_BITS-1:0]);
    assign acc_next = acc_q + partial;

    // single-cycle ALU; subtraction is rn + ~val2 + cin so carry means no borrow
    always_comb begin
        alu_res  = '0;
        add_b    = val2;
        add_cin  = 1'b0;
        is_arith = 1'b0;
        known    = 1'b1;
        case (exe_cmd)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_ADD: is_arith = 1'b1;
            CMD_ADC: begin is_arith = 1'b1; add_cin = sr[FLAG_C]; end
            CMD_SUB: begin is_arith = 1'b1; add_b = ~val2; add_cin = 1'b1; end
            CMD_SBC: begin is_arith = 1'b1; add_b = ~val2; add_cin = sr[FLAG_C]; end
            CMD_AND: alu_res = val_rn & val2;
            CMD_ORR: alu_res = val_rn | val2;
            CMD_EOR: alu_res = val_rn ^ val2;
            default: known = 1'b0;
        endcase
        sum = {1'b0, val_rn} + {1'b0, add_b} + (DATA_W+1)'(add_cin);
        alu_flags         = sr;
        alu_flags[FLAG_C] = sr[FLAG_C];
        alu_flags[FLAG_V] = sr[FLAG_V];
        if (is_arith) begin
            alu_res           = sum[DATA_W-1:0];
            alu_flags[FLAG_C] = sum[DATA_W];
            alu_flags[FLAG_V] = (val_rn[MSB] == add_b[MSB]) && (sum[MSB] != val_rn[MSB]);
        end
        if (known) begin
            alu_flags[FLAG_N] = alu_res[MSB];
            alu_flags[FLAG_Z] = (alu_res == '0);
        end
    end

    // next state: flush beats multiply completion, which beats a new accept
    always_comb begin
        state_d      = state_q;      step_d      = step_q;
        m_rm_d       = m_rm_q;       m_rs_d      = m_rs_q;     acc_d      = acc_q;
        m_s_d        = m_s_q;        m_cv_d      = m_cv_q;
        out_valid_d  = out_valid_q;  status_we_d = status_we_q;
        wb_en_d      = wb_en_q;      mem_r_en_d  = mem_r_en_q; mem_w_en_d = mem_w_en_q;
        dest_d       = dest_q;       status_d    = status_q;
        alu_result_d = alu_result_q; br_addr_d   = br_addr_q;  st_val_d   = st_val_q;
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            status_we_d = 1'b0;
        end else if (state_q == MUL) begin
            m_rm_d = m_rm_q << MUL_BITS;
            m_rs_d = m_rs_q >> MUL_BITS;
            acc_d  = acc_next;
            step_d = step_q + 1'b1;
            if (step_q == SCW'(MUL_STEPS - 1)) begin
                state_d          = IDLE;
                out_valid_d      = 1'b1;
                alu_result_d     = acc_next;
                status_d[FLAG_N] = acc_next[MSB];
                status_d[FLAG_Z] = (acc_next == '0);
                status_d[FLAG_C] = m_cv_q[1];
                status_d[FLAG_V] = m_cv_q[0];
                status_we_d      = m_s_q;
            end
        end else if (accept) begin
            // control, branch target and store data go straight to the output register
            wb_en_d    = wb_en_in;
            mem_r_en_d = mem_r_en_in;
            mem_w_en_d = mem_w_en_in;
            dest_d     = dest_in;
            br_addr_d  = br_calc;
            st_val_d   = val_rm;
            if (mul_op == MUL_NONE) begin
                out_valid_d  = 1'b1;
                alu_result_d = alu_res;
                status_d     = alu_flags;
                status_we_d  = s_in;
            end else begin
                state_d     = MUL;
                step_d      = '0;
                m_rm_d      = val_rm;
                m_rs_d      = val_rs;
                acc_d       = (mul_op == MUL_MLA) ? val_rn : '0;
                m_s_d       = s_in;
                m_cv_d      = {sr[FLAG_C], sr[FLAG_V]};
                out_valid_d = 1'b0;
                status_we_d = 1'b0;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            status_we_d = 1'b0;
        end
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;  step_q      <= '0;
            m_rm_q       <= '0;    m_rs_q      <= '0;   acc_q      <= '0;
            m_s_q        <= 1'b0;  m_cv_q      <= '0;
            out_valid_q  <= 1'b0;  status_we_q <= 1'b0;
            wb_en_q      <= 1'b0;  mem_r_en_q  <= 1'b0; mem_w_en_q <= 1'b0;
            dest_q       <= '0;    status_q    <= '0;
            alu_result_q <= '0;    br_addr_q   <= '0;   st_val_q   <= '0;
        end else begin
            state_q      <= state_d;      step_q      <= step_d;
            m_rm_q       <= m_rm_d;       m_rs_q      <= m_rs_d;     acc_q      <= acc_d;
            m_s_q        <= m_s_d;        m_cv_q      <= m_cv_d;
            out_valid_q  <= out_valid_d;  status_we_q <= status_we_d;
            wb_en_q      <= wb_en_d;      mem_r_en_q  <= mem_r_en_d; mem_w_en_q <= mem_w_en_d;
            dest_q       <= dest_d;       status_q    <= status_d;
            alu_result_q <= alu_result_d; br_addr_q   <= br_addr_d;  st_val_q   <= st_val_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign status_we  = status_we_q;
    assign wb_en      = wb_en_q;
    assign mem_r_en   = mem_r_en_q;
    assign mem_w_en   = mem_w_en_q;
    assign dest       = dest_q;
    assign status     = status_q;
    assign alu_result = alu_result_q;
    assign br_addr    = br_addr_q;
    assign st_val     = st_val_q;
    assign busy       = (state_q == MUL);

endmodule

// File: tb/tb_exe_stage_mc.sv
// tb/tb_exe_stage_mc.sv - scoreboard bench for exe_stage_mc
module tb_exe_stage_mc;

    localparam int STEPS = 8;

    typedef struct {
        logic        wb, mr, mw, s, im;
        logic [1:0]  mop;
        logic [3:0]  cmd, sr, dst;
        logic [11:0] so;
        logic [23:0] ims;
        logic [31:0] pc, rn, rm, rs;
    } bundle_t;

    typedef struct {
        logic [107:0] vec;
        int           acc_cyc;
        int           due;
        bit           is_mul;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic        wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0, s_in = 1'b0, imm = 1'b0;
    logic [1:0]  mul_op = '0;
    logic [3:0]  exe_cmd = '0, sr = '0, dest_in = '0;
    logic [11:0] shift_operand = '0;
    logic [23:0] imm_signed = '0;
    logic [31:0] pc_in = '0, val_rn = '0, val_rm = '0, val_rs = '0;
    logic        in_ready, out_valid, wb_en, mem_r_en, mem_w_en, status_we, busy;
    logic [3:0]  dest, status;
    logic [31:0] alu_result, br_addr, st_val;
    logic [107:0] dut_vec;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    logic fl_prev = 1'b0;
    exp_t sb[$];

    exe_stage_mc #(.DATA_W(32), .IMM_W(24), .MUL_BITS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .s_in(s_in), .imm(imm), .mul_op(mul_op), .exe_cmd(exe_cmd), .sr(sr),
        .dest_in(dest_in), .shift_operand(shift_operand), .imm_signed(imm_signed),
        .pc_in(pc_in), .val_rn(val_rn), .val_rm(val_rm), .val_rs(val_rs),
        .out_valid(out_valid), .out_ready(out_ready), .wb_en(wb_en), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .dest(dest), .alu_result(alu_result), .br_addr(br_addr),
        .st_val(st_val), .status(status), .status_we(status_we), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign dut_vec = {wb_en, mem_r_en, mem_w_en, dest, alu_result, br_addr, st_val, status, status_we};

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] val2_model(input bundle_t b);
        logic [31:0] x;
        int n;
        if (b.mr || b.mw) return {20'd0, b.so};
        if (b.im) begin
            x = {24'd0, b.so[7:0]};
            n = 2 * int'(b.so[11:8]);
            for (int i = 0; i < n; i++) x = {x[0], x[31:1]};
            return x;
        end
        x = b.rm;
        n = int'(b.so[11:7]);
        for (int i = 0; i < n; i++) begin
            case (b.so[6:5])
                2'b00:   x = {x[30:0], 1'b0};
                2'b01:   x = {1'b0, x[31:1]};
                2'b10:   x = {x[31], x[31:1]};
                default: x = {x[0], x[31:1]};
            endcase
        end
        return x;
    endfunction

    function automatic logic [107:0] predict(input bundle_t b);
        logic [31:0] v2, res, br;
        logic [3:0]  st;
        logic        c, v, known, arith;
        longint      a, bb, r, sa, sb, s, bw;
        logic [63:0] p;
        br = b.pc + 32'(longint'($signed(b.ims)) * 4);
        c = b.sr[1]; v = b.sr[0]; known = 1'b1; arith = 1'b0; res = '0; r = 0; s = 0;
        if (b.mop != 2'b00) begin
            p   = {32'd0, b.rm} * {32'd0, b.rs};
            res = p[31:0] + ((b.mop == 2'b10) ? b.rn : 32'd0);
            st  = {res[31], res == 32'd0, b.sr[1], b.sr[0]};
        end else begin
            v2 = val2_model(b);
            a  = longint'(b.rn);           bb = longint'(v2);
            sa = longint'($signed(b.rn));  sb = longint'($signed(v2));
            bw = b.sr[1] ? 0 : 1;
            case (b.cmd)
                4'h1: res = v2;
                4'h9: res = ~v2;
                4'h2: begin arith = 1; r = a + bb; s = sa + sb; c = (r >= 64'sh1_0000_0000); end
                4'h3: begin arith = 1; r = a + bb + (1 - bw); s = sa + sb + (1 - bw); c = (r >= 64'sh1_0000_0000); end
                4'h4: begin arith = 1; r = a - bb; s = sa - sb; c = (a >= bb); end
                4'h5: begin arith = 1; r = a - bb - bw; s = sa - sb - bw; c = (a >= bb + bw); end
                4'h6: res = b.rn & v2;
                4'h7: res = b.rn | v2;
                4'h8: res = b.rn ^ v2;
                default: known = 1'b0;
            endcase
            if (arith) begin
                res = r[31:0];
                v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            st = known ? {res[31], res == 32'd0, c, v} : b.sr;
        end
        return {b.wb, b.mr, b.mw, b.dst, res, br, b.rm, st, b.s};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        int m;
        b.wb = 1'($urandom); b.s = 1'($urandom); b.im = 1'($urandom);
        b.mr = ($urandom % 8 == 0); b.mw = ($urandom % 10 == 0);
        m = int'($urandom % 16);
        b.mop = (m < 12) ? 2'b00 : (m < 14) ? 2'b01 : (m < 15) ? 2'b10 : 2'b11;
        b.cmd = 4'($urandom); b.sr = 4'($urandom); b.dst = 4'($urandom);
        b.so = 12'($urandom); b.ims = 24'($urandom); b.pc = $urandom;
        b.rn = pick(); b.rm = pick(); b.rs = pick();
        return b;
    endfunction

    function automatic bundle_t mk(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                                   input logic [11:0] so, input logic im, input logic mr,
                                   input logic [1:0] mop, input logic [31:0] rs, input logic [3:0] srv);
        bundle_t b;
        b.wb = 1'b1; b.mr = mr; b.mw = 1'b0; b.s = 1'b1; b.im = im; b.mop = mop;
        b.cmd = cmd; b.sr = srv; b.dst = 4'd5; b.so = so; b.ims = 24'hFFFFFE; b.pc = 32'h20;
        b.rn = rn; b.rm = rm; b.rs = rs;
        return b;
    endfunction

    // one clock of stimulus; acceptance is decided by the bench's own view of the stage
    task automatic step(input logic v, input bundle_t b, input logic ordy, input logic fl, output logic acc);
        exp_t e;
        logic busy_e, outv_e, rdy_e;
        @(posedge clk);
        #1;
        if (fl_prev) sb.delete();
        #1;
        in_valid = v; flush = fl; out_ready = ordy;
        wb_en_in = b.wb; mem_r_en_in = b.mr; mem_w_en_in = b.mw; s_in = b.s; imm = b.im;
        mul_op = b.mop; exe_cmd = b.cmd; sr = b.sr; dest_in = b.dst; shift_operand = b.so;
        imm_signed = b.ims; pc_in = b.pc; val_rn = b.rn; val_rm = b.rm; val_rs = b.rs;
        #1;
        busy_e = (sb.size() > 0) && sb[$].is_mul && (sb[$].acc_cyc <= cyc) && (cyc < sb[$].due);
        outv_e = (sb.size() > 0) && (sb[0].due <= cyc);
        rdy_e  = !busy_e && (!outv_e || ordy) && !fl;
        check("in_ready", 128'(in_ready), 128'(rdy_e));
        acc = v && rdy_e;
        if (acc) begin
            e.vec     = predict(b);
            e.acc_cyc = cyc + 1;
            e.is_mul  = (b.mop != 2'b00);
            e.due     = cyc + 1 + (e.is_mul ? STEPS : 0);
            sb.push_back(e);
        end
        fl_prev = fl;
    endtask

    // monitor: compares whatever the output register presents against the scoreboard head
    always @(negedge clk) begin : monitor
        logic busy_e;
        if (mon_en) begin
            busy_e = (sb.size() > 0) && sb[$].is_mul && (sb[$].acc_cyc <= cyc) && (cyc < sb[$].due);
            check("busy", 128'(busy), 128'(busy_e));
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                check("out_valid", 128'(out_valid), 128'(1'b1));
                check("outputs", 128'(dut_vec), 128'(sb[0].vec));
                if (out_ready && !flush) void'(sb.pop_front());
            end else begin
                check("out_valid_idle", 128'(out_valid), 128'(1'b0));
                check("status_we_idle", 128'(status_we), 128'(1'b0));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        bundle_t dir[$];
        bundle_t b;
        logic acc;
        int k;

        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_status_we", 128'(status_we), 128'(1'b0));
        check("rst_outputs", 128'(dut_vec), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1'b1));
        rst = 1'b1;
        mon_en = 1;

        dir.push_back(mk(4'h2, 32'h7FFF_FFFF, 32'h0, 12'h001, 1'b1, 1'b0, 2'b00, 32'h0, 4'h0));
        dir.push_back(mk(4'h2, 32'h100, 32'h0, 12'hFFC, 1'b0, 1'b1, 2'b00, 32'h0, 4'h0));
        dir.push_back(mk(4'h1, 32'h0, 32'h0000_00F1, 12'h260, 1'b0, 1'b0, 2'b00, 32'h0, 4'h0));
        dir.push_back(mk(4'hF, 32'h1234, 32'h5, 12'h000, 1'b0, 1'b0, 2'b00, 32'h0, 4'hA));
        dir.push_back(mk(4'h0, 32'h3, 32'h0000_FFFF, 12'h000, 1'b0, 1'b0, 2'b10, 32'h0001_0001, 4'h3));
        dir.push_back(mk(4'h4, 32'h5, 32'h0, 12'h005, 1'b1, 1'b0, 2'b00, 32'h0, 4'h0));
        dir.push_back(mk(4'h5, 32'h8000_0000, 32'h0, 12'h001, 1'b1, 1'b0, 2'b00, 32'h0, 4'h0));
        dir.push_back(mk(4'h3, 32'hFFFF_FFFF, 32'h0, 12'h000, 1'b1, 1'b0, 2'b00, 32'h0, 4'h2));
        dir.push_back(mk(4'h1, 32'h0, 32'h8000_00F0, 12'h240, 1'b0, 1'b0, 2'b00, 32'h0, 4'h0));
        dir.push_back(mk(4'h9, 32'h0, 32'h0, 12'hF01, 1'b1, 1'b0, 2'b00, 32'h0, 4'h0));
        dir.push_back(mk(4'h0, 32'h7, 32'hFFFF_FFFF, 12'h000, 1'b0, 1'b0, 2'b01, 32'hFFFF_FFFF, 4'hF));

        // directed bundles with periodic three-cycle back-pressure while in_valid is held
        k = 0;
        foreach (dir[i]) begin
            acc = 1'b0;
            for (int t = 0; t < 60 && !acc; t++) begin
                step(1'b1, dir[i], !((k % 9) >= 3 && (k % 9) <= 5), 1'b0, acc);
                k++;
            end
            if (!acc) check("directed_accept", 128'(acc), 128'(1'b1));
        end

        // abort a multiply-accumulate four steps in
        b = mk(4'h0, 32'h3, 32'h0000_FFFF, 12'h000, 1'b0, 1'b0, 2'b10, 32'h0001_0001, 4'h0);
        repeat (12) step(1'b0, b, 1'b1, 1'b0, acc);
        acc = 1'b0;
        for (int t = 0; t < 30 && !acc; t++) step(1'b1, b, 1'b1, 1'b0, acc);
        repeat (4) step(1'b0, b, 1'b1, 1'b0, acc);
        step(1'b1, b, 1'b0, 1'b1, acc);
        step(1'b0, b, 1'b1, 1'b0, acc);
        check("flush_busy", 128'(busy), 128'(1'b0));
        check("flush_out_valid", 128'(out_valid), 128'(1'b0));

        // randomized traffic with back-pressure and occasional flushes
        b = rand_bundle();
        for (int t = 0; t < 900; t++) begin
            logic v, fl, ordy;
            v    = ($urandom % 10) < 7;
            fl   = ($urandom % 40) == 0;
            ordy = fl ? 1'b0 : (($urandom % 4) != 0);
            step(v, b, ordy, fl, acc);
            if (acc) b = rand_bundle();
        end

        repeat (STEPS + 6) step(1'b0, b, 1'b1, 1'b0, acc);
        check("drained", 128'(sb.size()), 128'(0));

        // asynchronous reset together with flush during a multiply
        b = mk(4'h0, 32'h1, 32'h1234_5678, 12'h000, 1'b0, 1'b0, 2'b01, 32'h9, 4'h0);
        acc = 1'b0;
        for (int t = 0; t < 30 && !acc; t++) step(1'b1, b, 1'b1, 1'b0, acc);
        repeat (3) step(1'b0, b, 1'b1, 1'b0, acc);
        @(posedge clk);
        #3;
        mon_en = 0;
        #1;
        flush = 1'b1;
        rst = 1'b0;
        #1;
        check("arst_busy", 128'(busy), 128'(1'b0));
        check("arst_out_valid", 128'(out_valid), 128'(1'b0));
        check("arst_outputs", 128'(dut_vec), 128'(0));
        @(posedge clk);
        #1;
        check("arst_hold", 128'({busy, out_valid, dut_vec}), 128'(0));
        sb.delete();
        rst = 1'b1;
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
